// File: rtl/seven_segments_pkg.sv
// rtl/seven_segments_pkg.sv - shared score glyph set, FSM states and score constants for the seven-segment interface
package seven_segments_pkg;

    // Active-high glyphs, bit6 = segment A .. bit0 = segment G
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_F     = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Line level with every segment off (lines are active-low)
    localparam logic [6:0] LINES_OFF = 7'h7F;

    localparam logic [3:0] SCORE_FINISH = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        SETTLING,
        LOCKED
    } seg_state_t;

endpackage

// File: rtl/seven_segments_stability_filter.sv
// rtl/seven_segments_stability_filter.sv - synchronises the segment lines and accepts a pattern once it has been stable
module seven_segments_stability_filter
    import seven_segments_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic [6:0] i_Lines,
    output logic [6:0] o_Pattern,
    output logic       o_Accept
);

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]       sync_1;
    logic [6:0]       sync_2;
    logic [6:0]       cand_lines;
    logic [CNT_W-1:0] cnt;
    seg_state_t       state;

    // Candidate and sampled lines stay in line (active-low) form; only the
    // output pattern is inverted, so reset "all off" is the same value everywhere.
    assign o_Pattern = ~cand_lines;

    // Accept fires on the edge where the candidate has been seen for the full window
    assign o_Accept = (state != LOCKED) && (sync_2 == cand_lines) && (cnt == CNT_TERM);

    // Synchroniser, candidate capture and stability timing FSM
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            sync_1     <= LINES_OFF;
            sync_2     <= LINES_OFF;
            cand_lines <= LINES_OFF;
            cnt        <= '0;
            state      <= IDLE;
        end else begin
            sync_1 <= i_Lines;
            sync_2 <= sync_1;
            if (sync_2 != cand_lines) begin
                // A new pattern always restarts timing, even on the terminal edge
                cand_lines <= sync_2;
                cnt        <= '0;
                state      <= SETTLING;
            end else begin
                case (state)
                    IDLE, SETTLING: begin
                        // IDLE times the reset pattern too, so a steady blank gets accepted
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_TERM) begin
                            state <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        // Counter parks at STABLE_CYCLES; no further accepts
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/seven_segments_decoder.sv
// rtl/seven_segments_decoder.sv - decodes filtered seven-segment lines into a score; SEVEN_SEGMENTS_ERR_COUNT_EN adds o_Err_Count
module seven_segments_decoder
    import seven_segments_pkg::*;
#(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Segment_A,
    input  logic       i_Segment_B,
    input  logic       i_Segment_C,
    input  logic       i_Segment_D,
    input  logic       i_Segment_E,
    input  logic       i_Segment_F,
    input  logic       i_Segment_G,
    output logic [3:0] o_Score,
    output logic       o_Valid,
    output logic       o_Update,
    output logic       o_Finish,
    output logic       o_Blank,
    output logic       o_Error
`ifdef SEVEN_SEGMENTS_ERR_COUNT_EN
    ,
    output logic [7:0] o_Err_Count
`endif
);

    logic [6:0] lines;
    logic [6:0] pattern;
    logic       accept;
    logic [6:0] accepted_lines;

    logic [3:0] dec_score;
    logic       dec_glyph;
    logic       dec_finish;
    logic       dec_blank;
    logic       dec_error;

    assign lines = {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                    i_Segment_E, i_Segment_F, i_Segment_G};

    seven_segments_stability_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Lines  (lines),
        .o_Pattern(pattern),
        .o_Accept (accept)
    );

    // Classify the candidate pattern against the score glyph set
    always_comb begin
        dec_score  = 4'd0;
        dec_glyph  = 1'b1;
        dec_finish = 1'b0;
        dec_blank  = 1'b0;
        case (pattern)
            SEG_1:     dec_score = 4'd1;
            SEG_2:     dec_score = 4'd2;
            SEG_3:     dec_score = 4'd3;
            SEG_4:     dec_score = 4'd4;
            SEG_5:     dec_score = 4'd5;
            SEG_6:     dec_score = 4'd6;
            SEG_7:     dec_score = 4'd7;
            SEG_8:     dec_score = 4'd8;
            SEG_9:     dec_score = 4'd9;
            SEG_F: begin
                dec_score  = SCORE_FINISH;
                dec_finish = 1'b1;
            end
            SEG_BLANK: begin
                dec_glyph = 1'b0;
                dec_blank = 1'b1;
            end
            default:   dec_glyph = 1'b0;
        endcase
    end

    assign dec_error = !dec_glyph && !dec_blank;

    // Accept step: latch status, keep the last valid score, pulse on a changed pattern
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            o_Score        <= 4'd0;
            o_Valid        <= 1'b0;
            o_Update       <= 1'b0;
            o_Finish       <= 1'b0;
            o_Blank        <= 1'b0;
            o_Error        <= 1'b0;
            accepted_lines <= LINES_OFF;
        end else begin
            o_Update <= 1'b0;
            if (accept) begin
                o_Valid        <= dec_glyph;
                o_Finish       <= dec_finish;
                o_Blank        <= dec_blank;
                o_Error        <= dec_error;
                o_Update       <= (pattern != ~accepted_lines);
                accepted_lines <= ~pattern;
                if (dec_glyph) begin
                    o_Score <= dec_score;
                end
            end
        end
    end

`ifdef SEVEN_SEGMENTS_ERR_COUNT_EN
    // Saturating count of accepted patterns that are neither glyph nor blank
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            o_Err_Count <= 8'd0;
        end else if (accept && dec_error && (o_Err_Count != 8'hFF)) begin
            o_Err_Count <= o_Err_Count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seven_segments_decoder.sv
// tb/tb_seven_segments_decoder.sv - self-checking bench for seven_segments_decoder with a run-length reference model
module tb_seven_segments_decoder;

    localparam int STABLE = 16;

    logic       clk;
    logic       rst_l;
    logic [6:0] lines;
    logic [3:0] score;
    logic       valid, update, finish, blank, error;
`ifdef SEVEN_SEGMENTS_ERR_COUNT_EN
    logic [7:0] err_count;
`endif

    int checks = 0;
    int errors = 0;

    seven_segments_decoder #(.STABLE_CYCLES(STABLE)) dut (
        .i_Clk      (clk),
        .i_Rst_L    (rst_l),
        .i_Segment_A(lines[6]),
        .i_Segment_B(lines[5]),
        .i_Segment_C(lines[4]),
        .i_Segment_D(lines[3]),
        .i_Segment_E(lines[2]),
        .i_Segment_F(lines[1]),
        .i_Segment_G(lines[0]),
        .o_Score    (score),
        .o_Valid    (valid),
        .o_Update   (update),
        .o_Finish   (finish),
        .o_Blank    (blank),
        .o_Error    (error)
`ifdef SEVEN_SEGMENTS_ERR_COUNT_EN
        ,
        .o_Err_Count(err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a line level becomes visible two edges after capture;
    // a pattern is accepted when it has been seen on STABLE+1 consecutive edges
    // (the reset pattern counts as already seen once).
    logic [6:0] glyphs [10] = '{7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                                7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h47};
    logic [6:0] m_h1, m_h2, m_p, m_cand, m_acc;
    int         m_run;
    int         m_idx;
    logic [3:0] e_score;
    logic       e_valid, e_update, e_finish, e_blank, e_error;
    int         e_err_count;

    always @(posedge clk) begin
        if (!rst_l) begin
            m_h1 = 7'h7F; m_h2 = 7'h7F; m_cand = 7'h00; m_acc = 7'h00; m_run = 1;
            e_score = 4'd0; e_valid = 0; e_update = 0; e_finish = 0; e_blank = 0; e_error = 0;
            e_err_count = 0;
        end else begin
            m_p = ~m_h2;
            m_h2 = m_h1;
            m_h1 = lines;
            e_update = 0;
            if (m_p == m_cand) m_run++;
            else begin
                m_cand = m_p;
                m_run = 1;
            end
            if (m_run == STABLE + 1) begin
                m_idx = -1;
                for (int i = 0; i < 10; i++) if (m_cand == glyphs[i]) m_idx = i;
                e_update = (m_cand != m_acc);
                m_acc = m_cand;
                e_finish = (m_idx == 9);
                e_valid = (m_idx >= 0);
                e_blank = (m_idx < 0) && (m_cand == 7'h00);
                e_error = (m_idx < 0) && (m_cand != 7'h00);
                if (m_idx >= 0) e_score = 4'(m_idx + 1);
                if (e_error && e_err_count < 255) e_err_count++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int nup;
        rst_l = 1'b0;
        lines = 7'h7F;
        repeat (3) tick();
        checks++;
        if ({score, valid, update, finish, blank, error} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: got score=%0d v=%b u=%b f=%b b=%b e=%b, want all 0",
                     score, valid, update, finish, blank, error);
        end
        rst_l = 1'b1;
        nup = 0;
        repeat (30) begin
            tick();
            if (update) nup++;
        end
        checks++;
        if (nup !== 0) begin
            errors++;
            $display("FAIL reset_blank_no_update: got %0d pulses, want 0", nup);
        end
        checks++;
        if ({blank, valid, score, error} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_blank_status: got b=%b v=%b score=%0d e=%b, want b=1 v=0 score=0 e=0",
                     blank, valid, score, error);
        end
    endtask

    task automatic test_digit_five();
        int nup, upd_edge;
        lines = 7'h24;
        nup = 0;
        upd_edge = -1;
        for (int e = 0; e < 25; e++) begin
            tick();
            if (update) begin
                nup++;
                upd_edge = e;
            end
        end
        checks++;
        if (nup !== 1 || upd_edge !== STABLE + 2) begin
            errors++;
            $display("FAIL five_latency: got %0d pulses last at edge %0d, want 1 at edge %0d",
                     nup, upd_edge, STABLE + 2);
        end
        checks++;
        if ({score, valid, blank, error, finish} !== {4'd5, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL five_status: got score=%0d v=%b b=%b e=%b f=%b, want 5 1 0 0 0",
                     score, valid, blank, error, finish);
        end
    endtask

    task automatic test_glitch();
        int nup;
        nup = 0;
        lines = 7'h00;
        repeat (10) begin
            tick();
            if (update) nup++;
        end
        lines = 7'h24;
        repeat (30) begin
            tick();
            if (update) nup++;
        end
        checks++;
        if (nup !== 0 || score !== 4'd5 || valid !== 1'b1) begin
            errors++;
            $display("FAIL glitch: got pulses=%0d score=%0d v=%b, want 0 5 1", nup, score, valid);
        end
    endtask

    task automatic test_finish();
        int nup;
        nup = 0;
        lines = 7'h38;
        repeat (30) begin
            tick();
            if (update) nup++;
        end
        checks++;
        if (nup !== 1 || {score, finish, valid} !== {4'd10, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL finish: got pulses=%0d score=%0d f=%b v=%b, want 1 10 1 1",
                     nup, score, finish, valid);
        end
    endtask

    task automatic test_error();
        lines = 7'h24;
        repeat (30) tick();
        lines = 7'h7E;
        repeat (30) tick();
        checks++;
        if ({error, valid, score, finish, blank} !== {1'b1, 1'b0, 4'd5, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL error_status: got e=%b v=%b score=%0d f=%b b=%b, want 1 0 5 0 0",
                     error, valid, score, finish, blank);
        end
`ifdef SEVEN_SEGMENTS_ERR_COUNT_EN
        checks++;
        if (err_count !== 8'd1) begin
            errors++;
            $display("FAIL error_count: got %0d, want 1", err_count);
        end
`endif
    endtask

    task automatic test_reset_mid_settle();
        int nup, upd_edge;
        nup = 0;
        lines = 7'h06;
        repeat (13) begin
            tick();
            if (update) nup++;
        end
        rst_l = 1'b0;
        tick();
        checks++;
        if (nup !== 0 || {score, valid, update, finish, blank, error} !== 9'd0) begin
            errors++;
            $display("FAIL mid_reset: got pulses=%0d score=%0d v=%b u=%b f=%b b=%b e=%b, want 0 and all 0",
                     nup, score, valid, update, finish, blank, error);
        end
        rst_l = 1'b1;
        nup = 0;
        upd_edge = -1;
        for (int e = 0; e < 25; e++) begin
            tick();
            if (update) begin
                nup++;
                upd_edge = e;
            end
        end
        checks++;
        if (nup !== 1 || upd_edge !== STABLE + 2 || score !== 4'd3) begin
            errors++;
            $display("FAIL post_reset_three: got pulses=%0d at edge %0d score=%0d, want 1 at %0d score 3",
                     nup, upd_edge, score, STABLE + 2);
        end
    endtask

    task automatic test_back_to_back();
        int nup;
        // Change lands on the terminal edge: nothing accepted
        nup = 0;
        lines = 7'h24;
        repeat (STABLE) begin
            tick();
            if (update) nup++;
        end
        lines = 7'h06;
        repeat (30) begin
            tick();
            if (update) nup++;
        end
        checks++;
        if (nup !== 0 || score !== 4'd3) begin
            errors++;
            $display("FAIL terminal_change: got pulses=%0d score=%0d, want 0 3", nup, score);
        end
        // One edge longer: the first pattern is accepted before the change
        nup = 0;
        lines = 7'h24;
        repeat (STABLE + 1) begin
            tick();
            if (update) nup++;
        end
        lines = 7'h06;
        repeat (30) begin
            tick();
            if (update) nup++;
        end
        checks++;
        if (nup !== 2 || score !== 4'd3) begin
            errors++;
            $display("FAIL just_stable: got pulses=%0d score=%0d, want 2 3", nup, score);
        end
    endtask

    task automatic test_random();
        int hold;
        int pick;
        for (int seg = 0; seg < 60; seg++) begin
            pick = $urandom_range(0, 13);
            if (pick < 10) lines = ~glyphs[pick];
            else if (pick == 10) lines = 7'h7F;
            else lines = 7'($urandom);
            if ($urandom_range(0, 19) == 0) rst_l = 1'b0;
            hold = $urandom_range(1, 24);
            for (int c = 0; c < hold; c++) begin
                tick();
                rst_l = 1'b1;
                checks++;
                if ({score, valid, update, finish, blank, error} !==
                    {e_score, e_valid, e_update, e_finish, e_blank, e_error}) begin
                    errors++;
                    $display("FAIL random_seg%0d: got score=%0d v=%b u=%b f=%b b=%b e=%b, want score=%0d v=%b u=%b f=%b b=%b e=%b",
                             seg, score, valid, update, finish, blank, error,
                             e_score, e_valid, e_update, e_finish, e_blank, e_error);
                end
`ifdef SEVEN_SEGMENTS_ERR_COUNT_EN
                checks++;
                if (int'(err_count) !== e_err_count) begin
                    errors++;
                    $display("FAIL random_errcnt%0d: got %0d, want %0d", seg, err_count, e_err_count);
                end
`endif
            end
        end
    endtask

    initial begin
        rst_l = 1'b0;
        lines = 7'h7F;
        test_reset();
        test_digit_five();
        test_glitch();
        test_finish();
        test_error();
        test_reset_mid_settle();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_segments_decoder.md
Name: seven_segments_decoder

Overview:
- Decodes the seven active-low segment lines back into a score value: the receiving end of the seven-segment display interface.
- Used for self-check loopback of the display drive, and to read a second board's score display.
- Synchronises the lines, filters glitches by requiring a stable pattern, then decodes it against the team's score glyph set (1-9, F = finish).
- Reports the decoded value, a change strobe, and finish/blank/error status.

Parameters:
- STABLE_CYCLES, 16, consecutive identical synchronised samples required before a pattern is accepted (legal range 2..255).
- CNT_W, $clog2(STABLE_CYCLES+1), stability counter width; derived, not overridden.

Ports:
- i_Clk  input  1  system clock
- i_Rst_L  input  1  reset, synchronous, active-low
- i_Segment_A..i_Segment_G  input  1 each  segment lines, active-low (0 = lit), asynchronous to i_Clk
- o_Score  output  4  last accepted valid score: 1..9, or 10 for F
- o_Valid  output  1  level; the currently accepted pattern is a valid glyph
- o_Update  output  1  one-cycle pulse when a newly accepted pattern differs from the previous accepted one
- o_Finish  output  1  level; accepted pattern is F
- o_Blank  output  1  level; accepted pattern has all segments off
- o_Error  output  1  level; accepted pattern is neither a glyph nor blank

Behaviour:
- Reset (i_Rst_L=0 at a rising edge) clears:
  - o_Score=0 and all status outputs (o_Valid, o_Update, o_Finish, o_Blank, o_Error) = 0.
  - Synchroniser flops to 7'h7F (segments off), counter=0, state IDLE, accepted-pattern register to 7'h7F.
- Input path:
  - Two-flop synchroniser per line.
  - Inversion to active-high pattern P[6:0], bit6=A .. bit0=G.
- Glyph table (active-high): 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, F=47, blank=00. All other values are errors.
- FSM states:
  - IDLE: nothing accepted since reset.
  - SETTLING: candidate pattern being timed.
  - LOCKED: candidate accepted.
- Transitions:
  - In any state, P differs from the candidate register: candidate<=P, counter<=0, state<=SETTLING.
  - In SETTLING, P equals the candidate: counter increments. When it reaches STABLE_CYCLES-1, go to LOCKED and run the accept step on the same edge.
  - In LOCKED, P equal: hold; no further pulses.
- Accept step (registered):
  - Glyph 1-9: o_Score=value, o_Valid=1, others 0.
  - Glyph F: o_Score=10, o_Valid=1, o_Finish=1.
  - Blank: o_Blank=1, o_Valid=0, o_Score holds.
  - Error: o_Error=1, o_Valid=0, o_Score holds.
  - o_Update=1 for exactly one cycle if the candidate differs from the previously accepted pattern. The first acceptance after reset always pulses, except blank (the accepted-pattern register resets to blank).
- Latency: a pattern change is first captured at edge k. If held, the accept step occurs at edge k+STABLE_CYCLES+2 (two synchroniser edges, then STABLE_CYCLES equal samples).
- Boundary conditions:
  - A change on the same edge the counter would reach terminal: the change wins, the counter restarts, and there is no acceptance.
  - The counter never wraps; it saturates in LOCKED.
  - Glitch shorter than STABLE_CYCLES: outputs unchanged.
  - Reset mid-SETTLING or mid-LOCKED: immediate clear at the next edge. No pulse is emitted for the pre-reset pattern.

Optional Feature:
- Macro: SEVEN_SEGMENTS_ERR_COUNT_EN.
- Defined: adds output o_Err_Count[7:0]. It increments on every accept step that yields error, saturates at 255, and is cleared by reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package seven_segments_pkg holds:
  - Glyph constants SEG_1..SEG_9, SEG_F, SEG_BLANK (7-bit, active-high, bit6=A); also adopted by the display encoder.
  - FSM state typedef {IDLE, SETTLING, LOCKED}.
  - Finish score constant 4'd10.
- One sub-module: seven_segments_stability_filter. It contains the synchroniser, the candidate register, the counter and the FSM, and outputs the accepted pattern plus an accept strobe. Decoding stays in the top.

Test Plan (STABLE_CYCLES=16):
- Reset with lines all 1 for 30 cycles -> o_Blank=1, o_Valid=0, o_Update never pulses, o_Score=0.
- Drive ~5B (lines 7'h24) from edge 0 -> o_Update pulses only at edge 18, o_Score=5, o_Valid=1.
- After 5 is locked, drive 8 (lines 7'h00) for 10 cycles, then 5 -> no o_Update, o_Score stays 5.
- Drive ~47 (lines 7'h38), held -> o_Score=10, o_Finish=1, o_Valid=1, single o_Update.
- Drive invalid 7'h7E (only G lit) after 5 is locked -> o_Error=1, o_Valid=0, o_Score=5. With SEVEN_SEGMENTS_ERR_COUNT_EN defined, o_Err_Count=1.
- Assert i_Rst_L=0 at counter=10 while settling on 3 -> all outputs 0 next edge. After release with 3 held, o_Update at exactly 18 edges after the first post-reset capture.
